fpu_add_sub_pipe: RTL and testbench

FPU_ADD_SUB_PIPE -- requirements
Module: fpu_add_sub_pipe

---
 rtl/fpu_add_sub_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_fpu_add_sub_pipe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_add_sub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor (IEEE-style format,
// round to nearest even, denormal support, canonical quiet NaN).
module fpu_add_sub_pipe #(
   parameter int EXPW  = 5,
   parameter int FRACW = 10
) (
   input  logic                clock,
   input  logic                reset_l,
   input  logic                inValid,
   output logic                inReady,
   input  logic                sub,
   input  logic [EXPW+FRACW:0] opA,
   input  logic [EXPW+FRACW:0] opB,
   output logic                outValid,
   input  logic                outReady,
   output logic [EXPW+FRACW:0] result,
   output logic [2:0]          flags
);
   localparam int W   = 1 + EXPW + FRACW;
   localparam int MW  = FRACW + 5;          // carry, hidden, fraction, G, R, S
   localparam int SHW = $clog2(MW + 1);
   localparam logic [EXPW-1:0] EMAX = '1;
   localparam logic [W-1:0]    QNAN = {1'b0, EMAX, 1'b1, {(FRACW-1){1'b0}}};

   function automatic logic [EXPW-1:0] eff_exp(input logic [EXPW-1:0] e);
      return (e == '0) ? EXPW'(1) : e;
   endfunction

   function automatic logic [SHW-1:0] lead_zeros(input logic [MW-2:0] v);
      logic [SHW-1:0] n;
      logic           found;
      n     = '0;
      found = 1'b0;
      for (int i = MW - 2; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      n = n + SHW'(1);
         end
      end
      return n;
   endfunction

   logic adv;
   logic vld_p1, vld_p2, vld_p3;

   assign adv      = outReady || !vld_p3;
   assign inReady  = adv;
   assign outValid = vld_p3;

   logic             sign_a, sign_b, a_big, nan_in, inf_a, inf_b, inv_in, lost;
   logic [EXPW-1:0]  exp_a, exp_b, big_exp, sml_exp, exp_diff;
   logic [FRACW-1:0] frac_a, frac_b;
   logic [FRACW:0]   big_man, sml_man;
   logic [MW-2:0]    sml_ext, sml_shift, sml_mask;
   logic [SHW-1:0]   shamt;
   logic [MW-1:0]    big_al, sml_al;
   logic             spec_n, big_sign;
   logic [W-1:0]     spec_res_n;
   logic [2:0]       spec_flg_n;

   // Stage 1: unpack, detect specials, sort by magnitude, align smaller operand
   always_comb begin
      sign_a    = opA[W-1];
      sign_b    = opB[W-1] ^ sub;
      exp_a     = opA[W-2:FRACW];
      exp_b     = opB[W-2:FRACW];
      frac_a    = opA[FRACW-1:0];
      frac_b    = opB[FRACW-1:0];
      a_big     = (opA[W-2:0] >= opB[W-2:0]);
      big_sign  = a_big ? sign_a : sign_b;
      big_man   = a_big ? {exp_a != '0, frac_a} : {exp_b != '0, frac_b};
      sml_man   = a_big ? {exp_b != '0, frac_b} : {exp_a != '0, frac_a};
      big_exp   = eff_exp(a_big ? exp_a : exp_b);
      sml_exp   = eff_exp(a_big ? exp_b : exp_a);
      exp_diff  = big_exp - sml_exp;
      shamt     = (int'(exp_diff) > FRACW + 3) ? SHW'(FRACW + 3) : SHW'(exp_diff);
      sml_ext   = {sml_man, 3'b000};
      sml_shift = sml_ext >> shamt;
      sml_mask  = ((MW-1)'(1) << shamt) - (MW-1)'(1);
      lost      = |(sml_ext & sml_mask);
      big_al    = {1'b0, big_man, 3'b000};
      sml_al    = {1'b0, sml_shift[MW-2:1], sml_shift[0] | lost};
      nan_in    = (exp_a == EMAX && frac_a != '0) || (exp_b == EMAX && frac_b != '0);
      inf_a     = (exp_a == EMAX) && (frac_a == '0);
      inf_b     = (exp_b == EMAX) && (frac_b == '0);
      inv_in    = inf_a && inf_b && (sign_a != sign_b);
      spec_n    = nan_in || inf_a || inf_b;
      spec_res_n = QNAN;
      spec_flg_n = 3'b000;
      if (nan_in || inv_in) begin
         spec_res_n = QNAN;
         spec_flg_n = {inv_in && !nan_in, 2'b00};
      end else if (inf_a) begin
         spec_res_n = {sign_a, EMAX, {FRACW{1'b0}}};
      end else if (inf_b) begin
         spec_res_n = {sign_b, EMAX, {FRACW{1'b0}}};
      end
   end

   logic [MW-1:0]   big_p1, sml_p1;
   logic [EXPW-1:0] exp_p1;
   logic            sign_p1, eff_sub_p1, spec_p1;
   logic [W-1:0]    spec_res_p1;
   logic [2:0]      spec_flg_p1;

   // Stage 1 -> 2 datapath register
   always_ff @(posedge clock) begin
      if (adv) begin
         big_p1      <= big_al;
         sml_p1      <= sml_al;
         exp_p1      <= big_exp;
         sign_p1     <= big_sign;
         eff_sub_p1  <= sign_a ^ sign_b;
         spec_p1     <= spec_n;
         spec_res_p1 <= spec_res_n;
         spec_flg_p1 <= spec_flg_n;
      end
   end

   logic [MW-1:0]  sum_n;
   logic [SHW-1:0] lz_n;

   // Stage 2: mantissa add/subtract (big >= small, never negative) and LZC
   always_comb begin
      sum_n = eff_sub_p1 ? (big_p1 - sml_p1) : (big_p1 + sml_p1);
      lz_n  = lead_zeros(sum_n[MW-2:0]);
   end

   logic [MW-1:0]   sum_p2;
   logic [SHW-1:0]  lz_p2;
   logic [EXPW-1:0] exp_p2;
   logic            sign_p2, eff_sub_p2, spec_p2;
   logic [W-1:0]    spec_res_p2;
   logic [2:0]      spec_flg_p2;

   // Stage 2 -> 3 datapath register
   always_ff @(posedge clock) begin
      if (adv) begin
         sum_p2      <= sum_n;
         lz_p2       <= lz_n;
         exp_p2      <= exp_p1;
         sign_p2     <= sign_p1;
         eff_sub_p2  <= eff_sub_p1;
         spec_p2     <= spec_p1;
         spec_res_p2 <= spec_res_p1;
         spec_flg_p2 <= spec_flg_p1;
      end
   end

   logic [MW-2:0]    norm;
   logic [EXPW+1:0]  exp_n, exp_pk;
   logic [FRACW+1:0] rnd;
   logic [FRACW-1:0] frac_pk;
   logic             rnd_up, inexact;
   int unsigned      lz_i, lim_i, sh_i;
   logic [W-1:0]     res_n;
   logic [2:0]       flg_n;

   // Stage 3: normalise (left shift clamped at exponent 1), round to nearest even, pack
   always_comb begin
      exp_n = {2'b00, exp_p2};
      lz_i  = 32'(lz_p2);
      lim_i = 32'(exp_p2) - 32'd1;
      sh_i  = (lz_i > lim_i) ? lim_i : lz_i;
      if (sum_p2[MW-1]) begin
         norm  = {sum_p2[MW-1:2], sum_p2[1] | sum_p2[0]};
         exp_n = exp_n + (EXPW+2)'(1);
      end else begin
         norm  = sum_p2[MW-2:0] << sh_i;
         exp_n = exp_n - (EXPW+2)'(sh_i);
      end
      rnd_up  = norm[2] & (norm[3] | norm[1] | norm[0]);
      inexact = |norm[2:0];
      rnd     = {1'b0, norm[MW-2:3]} + (FRACW+2)'(rnd_up);
      if (!norm[MW-2]) begin
         exp_pk  = (EXPW+2)'(rnd[FRACW]);
         frac_pk = rnd[FRACW-1:0];
      end else if (rnd[FRACW+1]) begin
         exp_pk  = exp_n + (EXPW+2)'(1);
         frac_pk = rnd[FRACW:1];
      end else begin
         exp_pk  = exp_n;
         frac_pk = rnd[FRACW-1:0];
      end
      res_n = {sign_p2, exp_pk[EXPW-1:0], frac_pk};
      flg_n = {2'b00, inexact};
      if (spec_p2) begin
         res_n = spec_res_p2;
         flg_n = spec_flg_p2;
      end else if (sum_p2 == '0) begin
         res_n = {sign_p2 & ~eff_sub_p2, {(W-1){1'b0}}};
         flg_n = 3'b000;
      end else if (exp_pk >= {2'b00, EMAX}) begin
         res_n = {sign_p2, EMAX, {FRACW{1'b0}}};
         flg_n = 3'b011;
      end
   end

   // Valid chain and output register; all stages advance together or hold
   always_ff @(posedge clock or negedge reset_l) begin
      if (!reset_l) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         vld_p3 <= 1'b0;
         result <= '0;
         flags  <= '0;
      end else if (adv) begin
         vld_p1 <= inValid;
         vld_p2 <= vld_p1;
         vld_p3 <= vld_p2;
         result <= res_n;
         flags  <= flg_n;
      end
   end
endmodule

// File: tb/tb_fpu_add_sub_pipe.sv
// Directed bench for fpu_add_sub_pipe (half precision defaults).
module tb_fpu_add_sub_pipe;
   logic        clock = 1'b0;
   logic        reset_l = 1'b0;
   logic        inValid = 1'b0;
   logic        inReady;
   logic        sub = 1'b0;
   logic [15:0] opA = '0;
   logic [15:0] opB = '0;
   logic        outValid;
   logic        outReady = 1'b1;
   logic [15:0] result;
   logic [2:0]  flags;

   int checks = 0;
   int errors = 0;

   fpu_add_sub_pipe dut (
      .clock(clock), .reset_l(reset_l), .inValid(inValid), .inReady(inReady),
      .sub(sub), .opA(opA), .opB(opB), .outValid(outValid), .outReady(outReady),
      .result(result), .flags(flags)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Single operation on an empty pipeline; lat = cycles from acceptance edge to outValid
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [15:0] r, output logic [2:0] f, output int lat);
      @(posedge clock); #1;
      inValid = 1'b1; opA = a; opB = b; sub = s; outReady = 1'b1;
      @(posedge clock); #1;
      inValid = 1'b0;
      lat = 1;
      while (!outValid && lat < 10) begin
         @(posedge clock); #1;
         lat++;
      end
      r = result;
      f = flags;
   endtask

   // Stream table: {opA, opB, sub, expected result}
   function automatic logic [48:0] svec(input int i);
      case (i)
         0: return {16'h3C00, 16'h4000, 1'b0, 16'h4200};
         1: return {16'h3C00, 16'h3C00, 1'b1, 16'h0000};
         2: return {16'h3C00, 16'h1000, 1'b0, 16'h3C00};
         3: return {16'h0001, 16'h0001, 1'b0, 16'h0002};
         4: return {16'h0400, 16'h0001, 1'b1, 16'h03FF};
         5: return {16'h3C00, 16'h4000, 1'b1, 16'hBC00};
         6: return {16'h3C01, 16'h1000, 1'b0, 16'h3C02};
         default: return {16'h0200, 16'h0200, 1'b0, 16'h0400};
      endcase
   endfunction

   task automatic test_reset();
      #2;
      checks++;
      if (outValid !== 1'b0 || inReady !== 1'b1 || result !== 16'h0 || flags !== 3'b000) begin
         errors++;
         $display("FAIL reset_state: outValid=%b inReady=%b result=%h flags=%b, required 0 1 0000 000",
                  outValid, inReady, result, flags);
      end
      @(posedge clock); #1;
      reset_l = 1'b1;
   endtask

   task automatic test_basic();
      logic [15:0] r; logic [2:0] f; int lat;
      run_op(16'h3C00, 16'h4000, 1'b0, r, f, lat);
      checks++;
      if (r !== 16'h4200) begin errors++; $display("FAIL basic_result: got %h required 4200", r); end
      checks++;
      if (f !== 3'b000) begin errors++; $display("FAIL basic_flags: got %b required 000", f); end
      checks++;
      if (lat != 3) begin errors++; $display("FAIL basic_latency: got %0d required 3", lat); end
   endtask

   task automatic test_arith();
      logic [15:0] a, b, er, r; logic s; logic [2:0] ef, f; int lat;
      for (int i = 0; i < 10; i++) begin
         case (i)
            0: begin a = 16'h3C00; b = 16'h3C00; s = 1; er = 16'h0000; ef = 3'b000; end
            1: begin a = 16'h3C00; b = 16'h1000; s = 0; er = 16'h3C00; ef = 3'b001; end
            2: begin a = 16'h3C00; b = 16'h4000; s = 1; er = 16'hBC00; ef = 3'b000; end
            3: begin a = 16'h3C01; b = 16'h1000; s = 0; er = 16'h3C02; ef = 3'b001; end
            4: begin a = 16'h3C00; b = 16'h1001; s = 0; er = 16'h3C01; ef = 3'b001; end
            5: begin a = 16'h7800; b = 16'h0001; s = 1; er = 16'h7800; ef = 3'b001; end
            6: begin a = 16'h8000; b = 16'h8000; s = 0; er = 16'h8000; ef = 3'b000; end
            7: begin a = 16'h8000; b = 16'h0000; s = 1; er = 16'h8000; ef = 3'b000; end
            8: begin a = 16'h0000; b = 16'h0000; s = 1; er = 16'h0000; ef = 3'b000; end
            default: begin a = 16'h3C00; b = 16'hBC00; s = 0; er = 16'h0000; ef = 3'b000; end
         endcase
         run_op(a, b, s, r, f, lat);
         checks++;
         if (r !== er || f !== ef || lat != 3) begin
            errors++;
            $display("FAIL arith_%0d: %h op%0d %h gave %h/%b lat %0d, required %h/%b lat 3",
                     i, a, s, b, r, f, lat, er, ef);
         end
      end
   endtask

   task automatic test_special();
      logic [15:0] a, b, er, r; logic s; logic [2:0] ef, f; int lat;
      for (int i = 0; i < 8; i++) begin
         case (i)
            0: begin a = 16'h7BFF; b = 16'h7BFF; s = 0; er = 16'h7C00; ef = 3'b011; end
            1: begin a = 16'h7C00; b = 16'h7C00; s = 1; er = 16'h7E00; ef = 3'b100; end
            2: begin a = 16'h7BFF; b = 16'h4C00; s = 0; er = 16'h7C00; ef = 3'b011; end
            3: begin a = 16'h7C01; b = 16'h3C00; s = 0; er = 16'h7E00; ef = 3'b000; end
            4: begin a = 16'h7C00; b = 16'h3C00; s = 0; er = 16'h7C00; ef = 3'b000; end
            5: begin a = 16'h3C00; b = 16'h7C00; s = 1; er = 16'hFC00; ef = 3'b000; end
            6: begin a = 16'h7C00; b = 16'h7C00; s = 0; er = 16'h7C00; ef = 3'b000; end
            default: begin a = 16'hFC00; b = 16'h7E00; s = 0; er = 16'h7E00; ef = 3'b000; end
         endcase
         run_op(a, b, s, r, f, lat);
         checks++;
         if (r !== er || f !== ef || lat != 3) begin
            errors++;
            $display("FAIL special_%0d: %h op%0d %h gave %h/%b lat %0d, required %h/%b lat 3",
                     i, a, s, b, r, f, lat, er, ef);
         end
      end
   endtask

   task automatic test_denormal();
      logic [15:0] a, b, er, r; logic s; logic [2:0] f; int lat;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: begin a = 16'h0001; b = 16'h0001; s = 0; er = 16'h0002; end
            1: begin a = 16'h0400; b = 16'h0001; s = 1; er = 16'h03FF; end
            2: begin a = 16'h0200; b = 16'h0200; s = 0; er = 16'h0400; end
            default: begin a = 16'h0401; b = 16'h0400; s = 1; er = 16'h0001; end
         endcase
         run_op(a, b, s, r, f, lat);
         checks++;
         if (r !== er || f !== 3'b000 || lat != 3) begin
            errors++;
            $display("FAIL denormal_%0d: %h op%0d %h gave %h/%b lat %0d, required %h/000 lat 3",
                     i, a, s, b, r, f, lat, er);
         end
      end
   endtask

   // Stream 8 ops with outReady following pat; exp_cyc > 0 also checks total cycles
   task automatic test_stream(input string tag, input logic [31:0] pat, input int exp_cyc);
      int sent = 0, got = 0, cyc = 0, extra = 0;
      logic hold = 1'b0;
      logic [15:0] held = '0;
      logic [48:0] v;
      @(posedge clock); #1;
      while (got < 8 && cyc < 200) begin
         outReady = pat[cyc % 32];
         if (sent < 8) begin
            v = svec(sent);
            inValid = 1'b1; opA = v[48:33]; opB = v[32:17]; sub = v[16];
         end else begin
            inValid = 1'b0;
         end
         #1;
         if (hold) begin
            checks++;
            if (outValid !== 1'b1 || result !== held) begin
               errors++;
               $display("FAIL %s_hold: outValid=%b result=%h, required 1 %h", tag, outValid, result, held);
            end
         end
         if (outValid && outReady) begin
            v = svec(got);
            checks++;
            if (result !== v[15:0]) begin
               errors++;
               $display("FAIL %s_order_%0d: got %h required %h", tag, got, result, v[15:0]);
            end
            got++;
         end
         if (inValid && inReady) sent++;
         hold = outValid && !outReady;
         held = result;
         @(posedge clock); #1;
         cyc++;
      end
      inValid = 1'b0;
      outReady = 1'b1;
      checks++;
      if (got != 8 || sent != 8) begin
         errors++;
         $display("FAIL %s_count: got %0d sent %0d, required 8 8", tag, got, sent);
      end
      if (exp_cyc > 0) begin
         checks++;
         if (cyc != exp_cyc) begin
            errors++;
            $display("FAIL %s_throughput: took %0d cycles, required %0d", tag, cyc, exp_cyc);
         end
      end
      for (int i = 0; i < 5; i++) begin
         if (outValid) extra++;
         @(posedge clock); #1;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL %s_duplicate: %0d extra outputs, required 0", tag, extra);
      end
   endtask

   task automatic test_reset_inflight();
      int stale = 0, seen = 0;
      outReady = 1'b1;
      @(posedge clock); #1;
      for (int i = 0; i < 3; i++) begin
         inValid = 1'b1; opA = 16'h3C00; opB = (i == 1) ? 16'h3C00 : 16'h4000; sub = 1'b0;
         @(posedge clock); #1;
      end
      inValid = 1'b0;
      reset_l = 1'b0;
      #1;
      checks++;
      if (outValid !== 1'b0 || inReady !== 1'b1 || result !== 16'h0 || flags !== 3'b000) begin
         errors++;
         $display("FAIL inflight_reset_state: outValid=%b inReady=%b result=%h flags=%b, required 0 1 0000 000",
                  outValid, inReady, result, flags);
      end
      @(posedge clock); @(posedge clock); #1;
      reset_l = 1'b1;
      inValid = 1'b1; opA = 16'h3C00; opB = 16'h3C00; sub = 1'b0;
      #1;
      checks++;
      if (inReady !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_ready: inReady=%b required 1", inReady);
      end
      @(posedge clock); #1;
      inValid = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         if (outValid) begin
            if (i == 3 && result === 16'h4000) seen++;
            else stale++;
         end
         @(posedge clock); #1;
      end
      checks++;
      if (stale != 0 || seen != 1) begin
         errors++;
         $display("FAIL post_reset_output: stale %0d fresh %0d, required 0 1", stale, seen);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_arith();
      test_special();
      test_denormal();
      test_stream("back_to_back", 32'hFFFF_FFFF, 11);
      test_stream("stall", 32'hB53A_9C6D, 0);
      test_reset_inflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
